// File: rtl/rcu_pkg.sv
// Shared types and constants for the USB-style packet receive control unit.
package rcu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC_WAIT,
    PID_WAIT,
    DATA_WAIT,
    EOP_WAIT,
    ERR,
    ERR_EOP
  } rcu_state_e;

  localparam logic [7:0] DEFAULT_SYNC = 8'h80;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear, programmable rollover value and
// a registered flag that is high while the count equals the rollover value.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;

  always_comb begin
    count_d = count_q;
    flag_d  = flag_q;
    if (clear) begin
      count_d = '0;
      flag_d  = 1'b0;
    end else if (count_enable) begin
      if (count_q == rollover_val) count_d = NUM_CNT_BITS'(1);
      else                         count_d = count_q + NUM_CNT_BITS'(1);
      flag_d = (count_d == rollover_val);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;

endmodule

// File: rtl/rcv_control_unit.sv
// Packet-level receive FSM: validates SYNC/PID, streams payload bytes to the
// RX FIFO, checks EOP alignment and payload length, reports done or error.
module rcv_control_unit
  import rcu_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC,
  parameter int         MAX_BYTES = 64,
  parameter int         CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_edge,
  input  logic             shift_enable,
  input  logic             byte_received,
  input  logic             eop,
  input  logic [7:0]       rcv_data,
  output logic             rcving,
  output logic             timer_reset,
  output logic             w_enable,
  output logic [7:0]       rx_data,
  output logic [3:0]       pid,
  output logic             pid_valid,
  output logic             rx_error,
  output logic             packet_done,
  output logic [CNT_W-1:0] byte_count
);

  rcu_state_e state_q, state_d;
  logic       w_enable_q, w_enable_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [3:0] pid_q, pid_d;
  logic       pid_valid_q, pid_valid_d;
  logic       rx_error_q, rx_error_d;
  logic       done_q, done_d;
  logic       aligned_q, aligned_d;
  logic       cnt_clear, cnt_en, cnt_full;
  logic       eop_s, pid_ok;

  assign eop_s  = eop & shift_enable;
  assign pid_ok = (rcv_data[3:0] == ~rcv_data[7:4]);

  always_comb begin
    state_d     = state_q;
    w_enable_d  = 1'b0;
    rx_data_d   = rx_data_q;
    pid_d       = pid_q;
    pid_valid_d = pid_valid_q;
    rx_error_d  = rx_error_q;
    done_d      = 1'b0;
    aligned_d   = aligned_q;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_edge) begin
          state_d     = SYNC_WAIT;
          rx_error_d  = 1'b0;
          pid_valid_d = 1'b0;
          aligned_d   = 1'b0;
          cnt_clear   = 1'b1;
        end
      end
      SYNC_WAIT: begin
        if (byte_received) state_d = (rcv_data == SYNC_BYTE) ? PID_WAIT : ERR;
        if (eop_s)         state_d = ERR_EOP;
      end
      PID_WAIT: begin
        if (byte_received) begin
          if (pid_ok) begin
            pid_d       = rcv_data[3:0];
            pid_valid_d = 1'b1;
            aligned_d   = 1'b1;
            state_d     = DATA_WAIT;
          end else begin
            state_d = ERR;
          end
        end
        if (eop_s) state_d = ERR_EOP;
      end
      DATA_WAIT: begin
        if (shift_enable && !eop) aligned_d = 1'b0;
        // cnt_full mirrors byte_count == MAX_BYTES, so the counter never wraps
        if (byte_received) begin
          if (!cnt_full) begin
            w_enable_d = 1'b1;
            rx_data_d  = rcv_data;
            cnt_en     = 1'b1;
            aligned_d  = 1'b1;
          end else begin
            state_d = ERR;
          end
        end
        // an EOP landing on a byte boundary pulse is always treated as an error
        if (eop_s) state_d = (aligned_q && !byte_received) ? EOP_WAIT : ERR_EOP;
      end
      EOP_WAIT: begin
        if (d_edge) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      ERR: begin
        if (eop_s) state_d = ERR_EOP;
      end
      ERR_EOP: begin
        if (d_edge) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == ERR || state_d == ERR_EOP) rx_error_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      w_enable_q  <= 1'b0;
      rx_data_q   <= '0;
      pid_q       <= '0;
      pid_valid_q <= 1'b0;
      rx_error_q  <= 1'b0;
      done_q      <= 1'b0;
      aligned_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_enable_q  <= w_enable_d;
      rx_data_q   <= rx_data_d;
      pid_q       <= pid_d;
      pid_valid_q <= pid_valid_d;
      rx_error_q  <= rx_error_d;
      done_q      <= done_d;
      aligned_q   <= aligned_d;
    end
  end

  flex_counter #(
    .NUM_CNT_BITS(CNT_W)
  ) u_byte_cnt (
    .clk          (clk),
    .n_rst        (~rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .rollover_val (CNT_W'(MAX_BYTES)),
    .count_out    (byte_count),
    .rollover_flag(cnt_full)
  );

  assign rcving      = (state_q != IDLE);
  assign timer_reset = (state_q == IDLE);
  assign w_enable    = w_enable_q;
  assign rx_data     = rx_data_q;
  assign pid         = pid_q;
  assign pid_valid   = pid_valid_q;
  assign rx_error    = rx_error_q;
  assign packet_done = done_q;

endmodule
